// File: rtl/wbfetch_arbiter_pkg.sv
// wbfetch_arbiter_pkg
// Shared definitions for the two-requester Wishbone fetch arbiter:
//   owner_t  - registered bus owner (IDLE / OWN_A / OWN_B)
//   WB_AW    - default bus word-address width
//   WB_DW    - default bus data width (WB_DW/8 byte selects)
package wbfetch_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } owner_t;

    localparam int unsigned WB_AW = 24;
    localparam int unsigned WB_DW = 32;

endpackage

// File: rtl/wbfetch_arb_mux.sv
// wbfetch_arb_mux
// Combinational owner-indexed request mux and response demux.
// Ports:
//   i_owner                    current registered bus owner
//   i_a_* / i_b_*              requester cyc/stb/we/addr/data/sel
//   o_a_* / o_b_*              per-requester stall/ack/err
//   o_wb_*                     shared master-port request fields
//   i_wb_stall/ack/err/data    slave responses
//   o_data                     read data broadcast (= i_wb_data)
module wbfetch_arb_mux
    import wbfetch_arbiter_pkg::*;
#(
    parameter int unsigned AW               = WB_AW,
    parameter int unsigned DW               = WB_DW,
    parameter bit          OPT_ZERO_ON_IDLE = 1'b1
) (
    input  owner_t              i_owner,
    input  logic                i_a_cyc,
    input  logic                i_a_stb,
    input  logic                i_a_we,
    input  logic [AW-1:0]       i_a_addr,
    input  logic [DW-1:0]       i_a_data,
    input  logic [DW/8-1:0]     i_a_sel,
    output logic                o_a_stall,
    output logic                o_a_ack,
    output logic                o_a_err,
    input  logic                i_b_cyc,
    input  logic                i_b_stb,
    input  logic                i_b_we,
    input  logic [AW-1:0]       i_b_addr,
    input  logic [DW-1:0]       i_b_data,
    input  logic [DW/8-1:0]     i_b_sel,
    output logic                o_b_stall,
    output logic                o_b_ack,
    output logic                o_b_err,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [AW-1:0]       o_wb_addr,
    output logic [DW-1:0]       o_wb_data,
    output logic [DW/8-1:0]     o_wb_sel,
    input  logic                i_wb_stall,
    input  logic                i_wb_ack,
    input  logic                i_wb_err,
    input  logic [DW-1:0]       i_wb_data,
    output logic [DW-1:0]       o_data
);

    assign o_data = i_wb_data;

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        if (OPT_ZERO_ON_IDLE) begin
            o_wb_addr = '0;
            o_wb_data = '0;
            o_wb_sel  = '0;
        end else begin
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
            o_wb_sel  = i_a_sel;
        end
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;

        // Responses are qualified with the owner's cyc: a response arriving
        // as the owner drops cyc belongs to an abandoned cycle and is dropped.
        case (i_owner)
            OWN_A: begin
                o_wb_cyc  = i_a_cyc;
                o_wb_stb  = i_a_stb;
                o_wb_we   = i_a_we;
                o_wb_addr = i_a_addr;
                o_wb_data = i_a_data;
                o_wb_sel  = i_a_sel;
                o_a_stall = i_wb_stall;
                o_a_ack   = i_wb_ack && i_a_cyc;
                o_a_err   = i_wb_err && i_a_cyc;
            end
            OWN_B: begin
                o_wb_cyc  = i_b_cyc;
                o_wb_stb  = i_b_stb;
                o_wb_we   = i_b_we;
                o_wb_addr = i_b_addr;
                o_wb_data = i_b_data;
                o_wb_sel  = i_b_sel;
                o_b_stall = i_wb_stall;
                o_b_ack   = i_wb_ack && i_b_cyc;
                o_b_err   = i_wb_err && i_b_cyc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wbfetch_arbiter.sv
// wbfetch_arbiter
// Two-requester pipelined Wishbone arbiter. Requester A (video line fetch)
// and requester B share one master port; ownership lasts a whole bus cycle
// and every hand-over passes through at least one IDLE cycle.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_a_* / o_a_*              requester A request fields and stall/ack/err
//   i_b_* / o_b_*              requester B request fields and stall/ack/err
//   o_wb_* / i_wb_*            shared master port
//   o_data                     read data broadcast to both requesters
// Build option:
//   WBFETCH_ARBITER_ROUND_ROBIN_EN - on contention in IDLE grant the
//   requester that did not own last; otherwise A always wins.
module wbfetch_arbiter
    import wbfetch_arbiter_pkg::*;
#(
    parameter int unsigned AW               = WB_AW,
    parameter int unsigned DW               = WB_DW,
    parameter bit          OPT_ZERO_ON_IDLE = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_a_cyc,
    input  logic                i_a_stb,
    input  logic                i_a_we,
    input  logic [AW-1:0]       i_a_addr,
    input  logic [DW-1:0]       i_a_data,
    input  logic [DW/8-1:0]     i_a_sel,
    output logic                o_a_stall,
    output logic                o_a_ack,
    output logic                o_a_err,
    input  logic                i_b_cyc,
    input  logic                i_b_stb,
    input  logic                i_b_we,
    input  logic [AW-1:0]       i_b_addr,
    input  logic [DW-1:0]       i_b_data,
    input  logic [DW/8-1:0]     i_b_sel,
    output logic                o_b_stall,
    output logic                o_b_ack,
    output logic                o_b_err,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [AW-1:0]       o_wb_addr,
    output logic [DW-1:0]       o_wb_data,
    output logic [DW/8-1:0]     o_wb_sel,
    input  logic                i_wb_stall,
    input  logic                i_wb_ack,
    input  logic                i_wb_err,
    input  logic [DW-1:0]       i_wb_data,
    output logic [DW-1:0]       o_data
);

    owner_t owner;
`ifdef WBFETCH_ARBITER_ROUND_ROBIN_EN
    owner_t last_owner;
`endif

    // Grants are only issued from IDLE, so dropping cyc always costs one
    // idle bus cycle before the other requester can take over.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner <= IDLE;
`ifdef WBFETCH_ARBITER_ROUND_ROBIN_EN
            last_owner <= OWN_B;
`endif
        end else begin
            case (owner)
                IDLE: begin
`ifdef WBFETCH_ARBITER_ROUND_ROBIN_EN
                    if (i_a_cyc && (!i_b_cyc || last_owner == OWN_B)) begin
                        owner      <= OWN_A;
                        last_owner <= OWN_A;
                    end else if (i_b_cyc) begin
                        owner      <= OWN_B;
                        last_owner <= OWN_B;
                    end
`else
                    if (i_a_cyc)
                        owner <= OWN_A;
                    else if (i_b_cyc)
                        owner <= OWN_B;
`endif
                end
                OWN_A:   if (!i_a_cyc) owner <= IDLE;
                OWN_B:   if (!i_b_cyc) owner <= IDLE;
                default: owner <= IDLE;
            endcase
        end
    end

    wbfetch_arb_mux #(
        .AW               (AW),
        .DW               (DW),
        .OPT_ZERO_ON_IDLE (OPT_ZERO_ON_IDLE)
    ) u_mux (
        .i_owner    (owner),
        .i_a_cyc    (i_a_cyc),
        .i_a_stb    (i_a_stb),
        .i_a_we     (i_a_we),
        .i_a_addr   (i_a_addr),
        .i_a_data   (i_a_data),
        .i_a_sel    (i_a_sel),
        .o_a_stall  (o_a_stall),
        .o_a_ack    (o_a_ack),
        .o_a_err    (o_a_err),
        .i_b_cyc    (i_b_cyc),
        .i_b_stb    (i_b_stb),
        .i_b_we     (i_b_we),
        .i_b_addr   (i_b_addr),
        .i_b_data   (i_b_data),
        .i_b_sel    (i_b_sel),
        .o_b_stall  (o_b_stall),
        .o_b_ack    (o_b_ack),
        .o_b_err    (o_b_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .i_wb_data  (i_wb_data),
        .o_data     (o_data)
    );

endmodule

// File: tb/tb_wbfetch_arbiter.sv
// tb_wbfetch_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a requester-indexed reference model of the arbitration rules.
module tb_wbfetch_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW/8;
    localparam bit ZERO_IDLE = 1'b1;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0]   i_a_addr, i_b_addr;
    logic [DW-1:0]   i_a_data, i_b_data;
    logic [SW-1:0]   i_a_sel, i_b_sel;
    logic            o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data, i_wb_data, o_data;
    logic [SW-1:0]   o_wb_sel;
    logic            i_wb_stall, i_wb_ack, i_wb_err;

    always #5 i_clk = ~i_clk;

    wbfetch_arbiter #(
        .AW               (AW),
        .DW               (DW),
        .OPT_ZERO_ON_IDLE (ZERO_IDLE)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_a_cyc    (i_a_cyc),
        .i_a_stb    (i_a_stb),
        .i_a_we     (i_a_we),
        .i_a_addr   (i_a_addr),
        .i_a_data   (i_a_data),
        .i_a_sel    (i_a_sel),
        .o_a_stall  (o_a_stall),
        .o_a_ack    (o_a_ack),
        .o_a_err    (o_a_err),
        .i_b_cyc    (i_b_cyc),
        .i_b_stb    (i_b_stb),
        .i_b_we     (i_b_we),
        .i_b_addr   (i_b_addr),
        .i_b_data   (i_b_data),
        .i_b_sel    (i_b_sel),
        .o_b_stall  (o_b_stall),
        .o_b_ack    (o_b_ack),
        .o_b_err    (o_b_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .i_wb_data  (i_wb_data),
        .o_data     (o_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: who holds the bus (-1 nobody, 0 = A, 1 = B) and
    // which requester was granted most recently.
    int holder = -1;
    int last   = 1;
    int a_acks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, compare all outputs mid-cycle, then
    // advance the model across the clock edge.
    task automatic step(input logic rst, input logic ac, input logic as_, input logic bc,
                        input logic bs, input logic st, input logic ak, input logic er);
        logic          cyc[2], stb[2], we[2];
        logic [AW-1:0] adr[2];
        logic [DW-1:0] dat[2];
        logic [SW-1:0] sel[2];
        logic          e_stall[2], e_ack[2], e_err[2];
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat, rdat;
        logic [SW-1:0] e_sel;

        cyc[0] = ac; stb[0] = as_; cyc[1] = bc; stb[1] = bs;
        for (int i = 0; i < 2; i++) begin
            we[i]  = 1'($urandom);
            adr[i] = AW'($urandom);
            dat[i] = $urandom;
            sel[i] = SW'($urandom);
        end
        rdat = $urandom;

        i_reset  = rst;
        i_a_cyc  = cyc[0]; i_a_stb = stb[0]; i_a_we = we[0];
        i_a_addr = adr[0]; i_a_data = dat[0]; i_a_sel = sel[0];
        i_b_cyc  = cyc[1]; i_b_stb = stb[1]; i_b_we = we[1];
        i_b_addr = adr[1]; i_b_data = dat[1]; i_b_sel = sel[1];
        i_wb_stall = st; i_wb_ack = ak; i_wb_err = er; i_wb_data = rdat;
        #4;

        e_stall[0] = 1'b1; e_stall[1] = 1'b1;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_err[0] = 1'b0; e_err[1] = 1'b0;
        if (holder < 0) begin
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = ZERO_IDLE ? '0 : adr[0];
            e_dat = ZERO_IDLE ? '0 : dat[0];
            e_sel = ZERO_IDLE ? '0 : sel[0];
        end else begin
            e_cyc = cyc[holder]; e_stb = stb[holder]; e_we = we[holder];
            e_adr = adr[holder]; e_dat = dat[holder]; e_sel = sel[holder];
            e_stall[holder] = st;
            e_ack[holder]   = ak && cyc[holder];
            e_err[holder]   = er && cyc[holder];
        end

        check("req", 128'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel}),
                     128'({e_cyc, e_stb, e_we, e_adr, e_dat, e_sel}));
        check("rsp", 128'({o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err, o_data}),
                     128'({e_stall[0], e_ack[0], e_err[0], e_stall[1], e_ack[1], e_err[1], rdat}));
        if (o_a_ack === 1'b1) a_acks++;

        if (rst) begin
            holder = -1;
            last   = 1;
        end else if (holder >= 0) begin
            if (!cyc[holder]) holder = -1;
        end else begin
            if (cyc[0] && cyc[1]) begin
`ifdef WBFETCH_ARBITER_ROUND_ROBIN_EN
                holder = 1 - last;
`else
                holder = 0;
`endif
            end else if (cyc[0]) holder = 0;
            else if (cyc[1]) holder = 1;
            if (holder >= 0) last = holder;
        end

        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic ac, bc;
        int   cnt;

        i_reset = 1'b1;
        {i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we} = '0;
        i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
        i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
        {i_wb_stall, i_wb_ack, i_wb_err} = '0;
        i_wb_data = '0;
        repeat (2) @(posedge i_clk);
        #1;

        // Reset state, then A alone: 4-beat read with acks two cycles behind.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        a_acks = 0;
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("a_acks", 128'(a_acks), 128'(4));
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Contention, with a 3-cycle slave stall in the first owner's burst.
        step(0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Bus error mid-burst, owner drops cyc the next cycle.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-burst, then a late ack while A still holds cyc.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // Random traffic with sticky cyc per requester.
        ac = 1'b0; bc = 1'b0;
        cnt = 0;
        repeat (3000) begin
            if ($urandom_range(7) == 0) ac = ~ac;
            if ($urandom_range(7) == 0) bc = ~bc;
            step($urandom_range(199) == 0,
                 ac, ac && 1'($urandom), bc, bc && 1'($urandom),
                 $urandom_range(3) == 0, $urandom_range(2) == 0,
                 $urandom_range(19) == 0);
            cnt++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wbfetch_arbiter.md
Name: wbfetch_arbiter

Overview:
Two-requester Wishbone (pipelined) bus arbiter. It shares the single memory-bus master port between the video line fetcher (requester A, the imgfifo read path) and a second requester B (frame writer or overlay fetcher). Ownership is held for a whole bus cycle, so a line burst is never split. A owns by default and B is admitted between A's line bursts.

Parameters:
AW, 24, bus word-address width
DW, 32, bus data width (DW/8 select bits)
OPT_ZERO_ON_IDLE, 1'b1, drive o_wb_addr/o_wb_data/o_wb_sel to zero when no owner

Ports:
i_clk  in  1  bus clock
i_reset  in  1  synchronous active-high reset
i_a_cyc  in  1  requester A bus cycle
i_a_stb  in  1  requester A strobe
i_a_we  in  1  requester A write enable
i_a_addr  in  AW  requester A address
i_a_data  in  DW  requester A write data
i_a_sel  in  DW/8  requester A byte select
o_a_stall  out  1  stall to A
o_a_ack  out  1  ack to A
o_a_err  out  1  bus error to A
i_b_*/o_b_*  in/out  as A  identical port set for requester B
o_wb_cyc  out  1  shared bus cycle
o_wb_stb  out  1  shared bus strobe
o_wb_we  out  1  shared write enable
o_wb_addr  out  AW  shared address
o_wb_data  out  DW  shared write data
o_wb_sel  out  DW/8  shared byte select
i_wb_stall  in  1  slave stall
i_wb_ack  in  1  slave ack
i_wb_err  in  1  slave error
i_wb_data  in  DW  slave read data
o_data  out  DW  read data broadcast to both requesters (= i_wb_data)

Behaviour:
- Clock i_clk; i_reset synchronous, active-high. Reset: owner=NONE, last_owner=B; all o_wb_* and o_a/b_* ack/err low; stalls high.
- States: IDLE, OWN_A, OWN_B. The owner is registered; the bus signals are a combinational mux of the owner's inputs.
- IDLE: o_wb_cyc=o_wb_stb=0; both stalls=1.
  - Next state OWN_A if i_a_cyc, else OWN_B if i_b_cyc, else stay IDLE (fixed A priority).
  - Grant latency is one cycle from cyc assertion; strobes seen in IDLE are stalled, not lost.
- OWN_x:
  - o_wb_cyc=i_x_cyc; o_wb_stb=i_x_stb; o_wb_we/addr/data/sel from x.
  - o_x_stall=i_wb_stall; o_x_ack=i_wb_ack; o_x_err=i_wb_err.
  - Non-owner: stall=1, ack=0, err=0.
- Release: when i_x_cyc=0, the next state is IDLE. An ack on the cycle x drops cyc is discarded, and o_wb_cyc falls in that same cycle.
- Error: i_wb_err is passed to the owner. The owner is expected to drop cyc, and the same release rule applies.
- Back-to-back: after release there is always at least one IDLE cycle, so ownership never switches without o_wb_cyc low for at least 1 cycle.
- i_reset mid-burst: owner=NONE next cycle and o_wb_cyc=0. Outstanding acks after reset are ignored (the owner is NONE, so ack/err to both requesters are low).
- o_data=i_wb_data always. Requesters qualify it with their own ack.
- OPT_ZERO_ON_IDLE=0: in IDLE, o_wb_addr/o_wb_data/o_wb_sel carry requester A's inputs.

Optional Feature:
- Macro WBFETCH_ARBITER_ROUND_ROBIN_EN.
- Defined: in IDLE with both cyc high, grant the requester that is not last_owner. last_owner updates on every grant.
- Undefined: fixed priority to A. last_owner logic is omitted.

Decomposition:
- Shared package: owner state encoding (IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10) and the bus field widths.
- One sub-module is natural: wbfetch_arb_mux, the combinational owner-indexed request mux and response demux. The FSM stays in the top module.

Test Plan:
- A alone: i_a_cyc/stb at t0 for a 4-beat read, ack 2 cycles later -> o_wb_cyc rises t1; A receives 4 acks; B stall=1 throughout; IDLE after A drops cyc.
- Contention (feature off): both cyc at t0 -> A granted t1; after A releases, B granted with exactly one IDLE cycle between.
- Contention (feature on, last_owner=A): both cyc -> B granted first; on the next contention A wins.
- Slave stall: i_wb_stall=1 for 3 cycles mid-burst -> o_a_stall=1 for those 3 cycles; o_wb_addr held; no beats lost.
- Error: i_wb_err during A's burst -> o_a_err=1 that cycle; B err=0; A drops cyc -> IDLE next cycle.
- Reset mid-burst: i_reset at beat 2 of 4 -> o_wb_cyc=0 next cycle; a late i_wb_ack produces no o_a_ack or o_b_ack.
